dmem_resp_v: RTL

//   Data-memory responder for the ARM datapath's load/store path. Accepts one

---
 rtl/dmem_pkg.sv | 24 ++
 rtl/dmem_resp_v_if.sv | 23 ++
 rtl/dmem_lane_v.sv | 29 ++
 rtl/dmem_resp_v.sv | 110 +++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding and byte-lane selects.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [1:0] LANE0 = 2'd0;
    localparam logic [1:0] LANE1 = 2'd1;
    localparam logic [1:0] LANE2 = 2'd2;
    localparam logic [1:0] LANE3 = 2'd3;

    function automatic logic [7:0] lane_byte(input logic [31:0] word, input logic [1:0] lane);
        case (lane)
            LANE0:   lane_byte = word[7:0];
            LANE1:   lane_byte = word[15:8];
            LANE2:   lane_byte = word[23:16];
            default: lane_byte = word[31:24];
        endcase
    endfunction

endpackage

// File: rtl/dmem_resp_v_if.sv
// Request/response bundle between the load/store controller and the data-memory responder.
interface dmem_resp_v_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_byte;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        busy;
    logic        err;

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, busy, err
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, busy, err
    );
endinterface

// File: rtl/dmem_lane_v.sv
// Byte-lane helper: merges a byte store into the old word and extracts a zero-extended
// byte for loads; word accesses pass straight through.
module dmem_lane_v
    import dmem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [31:0] wdata_i,
    input  logic [1:0]  lane_i,
    input  logic        byte_i,
    output logic [31:0] store_o,
    output logic [31:0] load_o
);

    always_comb begin
        store_o = wdata_i;
        load_o  = word_i;
        if (byte_i) begin
            store_o = word_i;
            load_o  = {24'h0, lane_byte(word_i, lane_i)};
            case (lane_i)
                LANE0:   store_o[7:0]   = wdata_i[7:0];
                LANE1:   store_o[15:8]  = wdata_i[7:0];
                LANE2:   store_o[23:16] = wdata_i[7:0];
                default: store_o[31:24] = wdata_i[7:0];
            endcase
        end
    end

endmodule

// File: rtl/dmem_resp_v.sv
// Single-outstanding data-memory responder with WAIT_CYCLES wait states.
// Optional DMEM_RANGE_CHECK_EN flags and suppresses accesses above the storage range.
module dmem_resp_v
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic          clk,
    input  logic          reset,
    dmem_resp_v_if.slave  bus
);

    localparam int CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W+1:0] addr_q;
    logic [31:0]       wdata_q;
    logic              write_q;
    logic              byte_q;
    logic              accept;
    logic              oor;
    logic              in_resp;
    logic              mem_we;
    logic [31:0]       store_word;
    logic [31:0]       load_word;
    logic [31:0]       mem_q [2**ADDR_W];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            write_q <= 1'b0;
            byte_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                addr_q  <= bus.req_addr[ADDR_W+1:0];
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
                byte_q  <= bus.req_byte;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    accept  = 1'b1;
                    cnt_d   = CNT_INIT;
                    state_d = (WAIT_CYCLES == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

`ifdef DMEM_RANGE_CHECK_EN
    logic oor_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)      oor_q <= 1'b0;
        else if (accept) oor_q <= |bus.req_addr[31:ADDR_W+2];
    end
    assign oor = oor_q;
`else
    // Upper address bits alias onto the storage array in this build.
    logic unused_addr_hi;
    assign unused_addr_hi = ^bus.req_addr[31:ADDR_W+2];
    assign oor = 1'b0;
`endif

    dmem_lane_v u_lane (
        .word_i  (mem_q[addr_q[ADDR_W+1:2]]),
        .wdata_i (wdata_q),
        .lane_i  (addr_q[1:0]),
        .byte_i  (byte_q),
        .store_o (store_word),
        .load_o  (load_word)
    );

    assign in_resp = (state_q == RESP);
    assign mem_we  = in_resp && write_q && !oor;

    // Storage is deliberately left out of reset; only a completed RESP store writes it.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr_q[ADDR_W+1:2]] <= store_word;
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.resp_valid = in_resp;
    assign bus.resp_rdata = (in_resp && !write_q && !oor) ? load_word : 32'h0;
    assign bus.err        = in_resp && oor;

endmodule
